// File: rtl/riscv_core_pkg.sv
// Shared core-wide types: address/data words and the memory read arbiter state encoding.
package riscv_core_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } mem_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin pick: the requester named by rr_ptr_i wins when both ask.
module rr_arbiter (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic       grant_o,
    output logic       any_req_o
);

    logic w_pick_other;

    always_comb begin
        w_pick_other = ~req_i[rr_ptr_i];
        grant_o      = rr_ptr_i ^ w_pick_other;
        any_req_o    = |req_i;
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates icache/dcache line refills onto one AXI4-Lite read port; address and
// data are passed straight through to/from the granted requester, nothing is buffered.
module mem_read_arbiter
    import riscv_core_pkg::*;
#(
    parameter int BEATS_PER_LINE = 8,
    parameter int NUM_REQ        = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic  [NUM_REQ-1:0]       req_arvalid_i,
    output logic  [NUM_REQ-1:0]       req_arready_o,
    input  addr_t [NUM_REQ-1:0]       req_araddr_i,
    output logic  [NUM_REQ-1:0]       req_rvalid_o,
    output word_t [NUM_REQ-1:0]       req_rdata_o,
    input  logic  [NUM_REQ-1:0]       req_rready_i,
    output logic                      mem_arvalid_o,
    input  logic                      mem_arready_i,
    output addr_t                     mem_araddr_o,
    input  logic                      mem_rvalid_i,
    input  word_t                     mem_rdata_i,
    output logic                      mem_rready_o,
    output logic                      grant_o,
    output logic                      busy_o,
    output mem_arb_state_e            dbg_state_o,
    output logic                      dbg_rr_ptr_o
);

    localparam int                BEAT_W    = $clog2(BEATS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    mem_arb_state_e    r_state;
    mem_arb_state_e    w_state_next;
    logic              r_grant;
    logic              w_grant_next;
    logic              r_rr_ptr;
    logic              w_rr_ptr_next;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_next;
    logic              w_arb_grant;
    logic              w_any_req;

    rr_arbiter u_rr_arbiter (
        .req_i     (req_arvalid_i),
        .rr_ptr_i  (r_rr_ptr),
        .grant_o   (w_arb_grant),
        .any_req_o (w_any_req)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_grant    <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_beat_cnt <= w_beat_next;
        end
    end

    // A transfer on any channel happens in a cycle where its valid and ready are both high;
    // a requester that lowers arvalid before its address is accepted gives up its grant.
    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        w_beat_next   = r_beat_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_grant_next = w_arb_grant;
                    w_state_next = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (!req_arvalid_i[r_grant]) begin
                    w_state_next = ARB_IDLE;
                end else if (mem_arready_i) begin
                    w_state_next = ARB_DATA;
                    w_beat_next  = '0;
                end
            end
            ARB_DATA: begin
                if (mem_rvalid_i && req_rready_i[r_grant]) begin
                    w_beat_next = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_next  = ARB_IDLE;
                        w_rr_ptr_next = ~r_grant;
                    end
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // Everything not steered to the granted requester in the current phase stays at zero.
    always_comb begin
        req_arready_o = '0;
        req_rvalid_o  = '0;
        req_rdata_o   = '0;
        mem_arvalid_o = 1'b0;
        mem_araddr_o  = '0;
        mem_rready_o  = 1'b0;
        case (r_state)
            ARB_ADDR: begin
                mem_arvalid_o          = req_arvalid_i[r_grant];
                mem_araddr_o           = req_araddr_i[r_grant];
                req_arready_o[r_grant] = mem_arready_i;
            end
            ARB_DATA: begin
                req_rvalid_o[r_grant] = mem_rvalid_i;
                req_rdata_o[r_grant]  = mem_rdata_i;
                mem_rready_o          = req_rready_i[r_grant];
            end
            default: ;
        endcase
    end

    assign grant_o      = r_grant;
    assign busy_o       = (r_state != ARB_IDLE);
    assign dbg_state_o  = r_state;
    assign dbg_rr_ptr_o = r_rr_ptr;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed refill scenarios plus a random run,
// all compared against a line-level reference model and per-requester data scoreboards.
module tb_mem_read_arbiter;
    import riscv_core_pkg::*;

    localparam int BEATS = 8;

    // clock / reset
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_ni;

    logic  [1:0] req_arvalid_i;
    logic  [1:0] req_arready_o;
    addr_t [1:0] req_araddr_i;
    logic  [1:0] req_rvalid_o;
    word_t [1:0] req_rdata_o;
    logic  [1:0] req_rready_i;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    addr_t       mem_araddr_o;
    logic        mem_rvalid_i;
    word_t       mem_rdata_i;
    logic        mem_rready_o;
    logic        grant_o;
    logic        busy_o;
    mem_arb_state_e dbg_state_o;
    logic        dbg_rr_ptr_o;

    mem_read_arbiter #(.BEATS_PER_LINE(BEATS), .NUM_REQ(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_arvalid_i (req_arvalid_i),
        .req_arready_o (req_arready_o),
        .req_araddr_i  (req_araddr_i),
        .req_rvalid_o  (req_rvalid_o),
        .req_rdata_o   (req_rdata_o),
        .req_rready_i  (req_rready_i),
        .mem_arvalid_o (mem_arvalid_o),
        .mem_arready_i (mem_arready_i),
        .mem_araddr_o  (mem_araddr_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rready_o  (mem_rready_o),
        .grant_o       (grant_o),
        .busy_o        (busy_o),
        .dbg_state_o   (dbg_state_o),
        .dbg_rr_ptr_o  (dbg_rr_ptr_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: who owns the port, whether its address went out, beats moved
    bit m_owned, m_addr_done, m_owner, m_ptr;
    int m_beats;

    // memory responder
    bit    mem_busy;
    addr_t mem_line;
    int    mem_beat;

    // scoreboards and bookkeeping
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int rx_cnt[2];
    int ar_hs_cnt;
    bit grant_log[$];
    bit [1:0] hs_ar;
    bit persist;
    bit rnd_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic word_t word_of(addr_t a, int i);
        return (a ^ 32'h0000_1000) + 32'h0000_00A0 + word_t'(i);
    endfunction

    task automatic check_cycle();
        bit in_addr, in_data;
        logic e_arv, e_rr;
        addr_t e_addr;
        logic [1:0] e_arr, e_rv;
        logic [63:0] e_rd;
        mem_arb_state_e e_st;
        in_addr = m_owned && !m_addr_done;
        in_data = m_owned && m_addr_done;
        e_arv  = in_addr ? req_arvalid_i[m_owner] : 1'b0;
        e_addr = in_addr ? req_araddr_i[m_owner] : '0;
        e_arr  = in_addr ? (m_owner ? {mem_arready_i, 1'b0} : {1'b0, mem_arready_i}) : 2'b00;
        e_rv   = in_data ? (m_owner ? {mem_rvalid_i, 1'b0} : {1'b0, mem_rvalid_i}) : 2'b00;
        e_rd   = '0;
        if (in_data) e_rd = m_owner ? {mem_rdata_i, 32'h0} : {32'h0, mem_rdata_i};
        e_rr   = in_data ? req_rready_i[m_owner] : 1'b0;
        e_st   = !m_owned ? ARB_IDLE : (m_addr_done ? ARB_DATA : ARB_ADDR);
        check("busy", 64'(busy_o), 64'(m_owned));
        if (m_owned) check("grant", 64'(grant_o), 64'(m_owner));
        check("mem_arvalid", 64'(mem_arvalid_o), 64'(e_arv));
        check("mem_araddr", 64'(mem_araddr_o), 64'(e_addr));
        check("req_arready", 64'(req_arready_o), 64'(e_arr));
        check("req_rvalid", 64'(req_rvalid_o), 64'(e_rv));
        check("req_rdata", 64'(req_rdata_o), e_rd);
        check("mem_rready", 64'(mem_rready_o), 64'(e_rr));
        check("state", 64'(dbg_state_o), 64'(e_st));
        check("rr_ptr", 64'(dbg_rr_ptr_o), 64'(m_ptr));
    endtask

    task automatic observe();
        logic [31:0] w;
        for (int k = 0; k < 2; k++) begin
            if (req_rvalid_o[k] && req_rready_i[k]) begin
                rx_cnt[k]++;
                if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                    check($sformatf("rd_unexpected%0d", k), 64'd1, 64'd0);
                end else begin
                    w = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("rdata_sb%0d", k), 64'(req_rdata_o[k]), 64'(w));
                end
            end
            hs_ar[k] = req_arvalid_i[k] && req_arready_o[k];
        end
        if (mem_busy && mem_rvalid_i && mem_rready_o) begin
            mem_beat++;
            if (mem_beat == BEATS) mem_busy = 1'b0;
        end
        if (mem_arvalid_o && mem_arready_i) begin
            ar_hs_cnt++;
            grant_log.push_back(grant_o);
            mem_busy = 1'b1;
            mem_line = mem_araddr_o;
            mem_beat = 0;
        end
    endtask

    task automatic model_advance();
        if (!m_owned) begin
            if (|req_arvalid_i) begin
                m_owner     = req_arvalid_i[m_ptr] ? m_ptr : ~m_ptr;
                m_owned     = 1'b1;
                m_addr_done = 1'b0;
            end
        end else if (!m_addr_done) begin
            if (!req_arvalid_i[m_owner]) begin
                m_owned = 1'b0;
            end else if (mem_arready_i) begin
                m_addr_done = 1'b1;
                m_beats     = 0;
                for (int i = 0; i < BEATS; i++) begin
                    if (m_owner) exp_q1.push_back(word_of(req_araddr_i[1], i));
                    else         exp_q0.push_back(word_of(req_araddr_i[0], i));
                end
            end
        end else if (mem_rvalid_i && req_rready_i[m_owner]) begin
            m_beats++;
            if (m_beats == BEATS) begin
                m_owned = 1'b0;
                m_ptr   = ~m_owner;
            end
        end
    endtask

    // driver: random requesters, memory and consumers
    task automatic random_drive();
        for (int k = 0; k < 2; k++) begin
            if (!req_arvalid_i[k] && $urandom_range(3) == 0) begin
                req_arvalid_i[k] = 1'b1;
                req_araddr_i[k]  = addr_t'($urandom) & ~addr_t'(32'h1F);
            end else if (req_arvalid_i[k] && $urandom_range(31) == 0) begin
                req_arvalid_i[k] = 1'b0;
            end
            req_rready_i[k] = ($urandom_range(3) != 0);
        end
        mem_arready_i = ($urandom_range(2) != 0);
        mem_rvalid_i  = ($urandom_range(3) != 0);
    endtask

    task automatic step();
        mem_rdata_i = mem_busy ? word_of(mem_line, mem_beat) : word_t'($urandom);
        @(negedge clk_i);
        check_cycle();
        observe();
        model_advance();
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (hs_ar[k]) begin
                if (persist) req_araddr_i[k] = req_araddr_i[k] + 32'h100;
                else         req_arvalid_i[k] = 1'b0;
            end
        end
        if (rnd_mode) random_drive();
    endtask

    task automatic run_until_idle(input int max_cycles, input string tag);
        int n = 0;
        while ((m_owned || mem_busy || |req_arvalid_i || exp_q0.size() != 0 || exp_q1.size() != 0)
               && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, 64'(n < max_cycles), 64'd1);
    endtask

    task automatic step_until_rx(input int k, input int target, input string tag);
        int n = 0;
        while (rx_cnt[k] < target && n < 40) begin
            step();
            n++;
        end
        check(tag, 64'(n < 40), 64'd1);
    endtask

    // Pulses reset a couple of ns after a rising edge and checks the asynchronous clear.
    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_mem_arvalid", 64'(mem_arvalid_o), 64'd0);
        check("rst_mem_araddr", 64'(mem_araddr_o), 64'd0);
        check("rst_mem_rready", 64'(mem_rready_o), 64'd0);
        check("rst_req_arready", 64'(req_arready_o), 64'd0);
        check("rst_req_rvalid", 64'(req_rvalid_o), 64'd0);
        check("rst_req_rdata", 64'(req_rdata_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(ARB_IDLE));
        check("rst_rr_ptr", 64'(dbg_rr_ptr_o), 64'd0);
        m_owned = 1'b0; m_addr_done = 1'b0; m_owner = 1'b0; m_ptr = 1'b0; m_beats = 0;
        mem_busy = 1'b0; mem_beat = 0;
        exp_q0.delete(); exp_q1.delete();
        hs_ar = 2'b00; persist = 1'b0;
        req_arvalid_i = 2'b00;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int base0, base1, gl, hs0, hold;
        rst_ni = 1'b1;
        req_arvalid_i = 2'b00; req_araddr_i = '0; req_rready_i = 2'b00;
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        rnd_mode = 1'b0; ar_hs_cnt = 0; rx_cnt[0] = 0; rx_cnt[1] = 0;
        @(posedge clk_i);
        #1;
        do_reset();

        // single icache refill, 0xA0..0xA7
        req_araddr_i[0] = 32'h0000_1000; req_arvalid_i = 2'b01;
        mem_arready_i = 1'b1; mem_rvalid_i = 1'b1; req_rready_i = 2'b11;
        base0 = rx_cnt[0];
        run_until_idle(40, "t1_timeout");
        check("t1_beats", 64'(rx_cnt[0] - base0), 64'd8);
        check("t1_busy_after", 64'(busy_o), 64'd0);
        check("t1_rr_ptr", 64'(dbg_rr_ptr_o), 64'd1);

        // simultaneous requests after reset
        do_reset();
        req_araddr_i[0] = 32'h0000_1000; req_araddr_i[1] = 32'h0000_2000;
        req_arvalid_i = 2'b11; mem_arready_i = 1'b1; mem_rvalid_i = 1'b1; req_rready_i = 2'b11;
        gl = grant_log.size(); base0 = rx_cnt[0]; base1 = rx_cnt[1];
        run_until_idle(80, "t2_timeout");
        check("t2_lines", 64'(grant_log.size() - gl), 64'd2);
        if (grant_log.size() >= gl + 2) begin
            check("t2_first", 64'(grant_log[gl]), 64'd0);
            check("t2_second", 64'(grant_log[gl+1]), 64'd1);
        end
        check("t2_beats0", 64'(rx_cnt[0] - base0), 64'd8);
        check("t2_beats1", 64'(rx_cnt[1] - base1), 64'd8);

        // continuous contention: grants alternate
        do_reset();
        req_araddr_i[0] = 32'h0001_0000; req_araddr_i[1] = 32'h0002_0000;
        req_arvalid_i = 2'b11; persist = 1'b1;
        gl = grant_log.size();
        for (int n = 0; n < 200 && grant_log.size() < gl + 4; n++) step();
        persist = 1'b0;
        run_until_idle(120, "t3_timeout");
        check("t3_lines", 64'(grant_log.size() >= gl + 4), 64'd1);
        if (grant_log.size() >= gl + 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_grant%0d", i), 64'(grant_log[gl+i]), 64'(i % 2));
        end

        // dcache consumer stalls three cycles mid-line
        req_araddr_i[1] = 32'h0000_3000; req_arvalid_i = 2'b10;
        base1 = rx_cnt[1];
        step_until_rx(1, base1 + 3, "t4_reach");
        req_rready_i[1] = 1'b0;
        hold = rx_cnt[1];
        repeat (3) step();
        check("t4_hold", 64'(rx_cnt[1]), 64'(hold));
        req_rready_i[1] = 1'b1;
        run_until_idle(40, "t4_timeout");
        check("t4_beats", 64'(rx_cnt[1] - base1), 64'd8);

        // reset after the fourth beat of an icache line
        req_araddr_i[0] = 32'h0000_4000; req_arvalid_i = 2'b01;
        base0 = rx_cnt[0];
        step_until_rx(0, base0 + 4, "t5_reach");
        do_reset();
        repeat (3) step();
        check("t5_no_beats", 64'(rx_cnt[0] - base0), 64'd4);
        req_araddr_i[1] = 32'h0000_5000; req_arvalid_i = 2'b10;
        gl = grant_log.size(); base1 = rx_cnt[1];
        run_until_idle(40, "t5_timeout");
        check("t5_lines", 64'(grant_log.size() - gl), 64'd1);
        if (grant_log.size() > gl) check("t5_grant", 64'(grant_log[gl]), 64'd1);
        check("t5_beats1", 64'(rx_cnt[1] - base1), 64'd8);

        // icache withdraws its request before the address is accepted
        req_araddr_i[0] = 32'h0000_6000; req_arvalid_i = 2'b01; mem_arready_i = 1'b0;
        hs0 = ar_hs_cnt;
        step(); step();
        req_arvalid_i = 2'b00;
        step(); step();
        check("t6_no_hs", 64'(ar_hs_cnt), 64'(hs0));
        check("t6_rr_ptr", 64'(dbg_rr_ptr_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);

        // random traffic
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        mem_arready_i = 1'b1; mem_rvalid_i = 1'b1; req_rready_i = 2'b11;
        run_until_idle(400, "drain_timeout");
        check("drain_q0", 64'(exp_q0.size()), 64'd0);
        check("drain_q1", 64'(exp_q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter BEATS_PER_LINE, default 8, meaning R beats per line refill (power of 2, >=2).
REQ-002 SHALL have parameter NUM_REQ, fixed at 2, meaning requesters (0 = icache refill, 1 = dcache refill).
REQ-003 clk_i  input  1  clock; all logic rising-edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_arvalid_i  input  [NUM_REQ]  per-requester read address valid.
REQ-006 req_arready_o  output  [NUM_REQ]  per-requester read address ready.
REQ-007 req_araddr_i  input  [NUM_REQ] x addr_t  per-requester line base address.
REQ-008 req_rvalid_o  output  [NUM_REQ]  per-requester read data valid.
REQ-009 req_rdata_o  output  [NUM_REQ] x word_t  per-requester read data.
REQ-010 req_rready_i  input  [NUM_REQ]  per-requester read data ready.
REQ-011 mem_arvalid_o / mem_arready_i / mem_araddr_o (addr_t)  out/in/out  AXI4-Lite read address channel to memory.
REQ-012 mem_rvalid_i / mem_rdata_i (word_t) / mem_rready_o  in/in/out  AXI4-Lite read data channel.
REQ-013 grant_o  output  1  index of currently granted requester; valid while busy_o=1.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ADDR, DATA in a registered state machine.
REQ-016 IDLE: if any req_arvalid_i high, SHALL latch grant by round-robin (requester equal to rr_ptr wins a tie) and enter ADDR next cycle; otherwise stay IDLE.
REQ-017 ADDR: mem_arvalid_o SHALL equal req_arvalid_i[grant], mem_araddr_o SHALL equal req_araddr_i[grant], req_arready_o[grant] SHALL equal mem_arready_i.
REQ-018 ADDR: on mem_arvalid_o && mem_arready_i SHALL enter DATA and clear beat counter.
REQ-019 ADDR: if req_arvalid_i[grant] drops before handshake, SHALL return to IDLE with rr_ptr unchanged.
REQ-020 DATA: req_rvalid_o[grant]=mem_rvalid_i, req_rdata_o[grant]=mem_rdata_i, mem_rready_o=req_rready_i[grant].
REQ-021 DATA: each mem_rvalid_i && mem_rready_o SHALL increment beat counter ($clog2(BEATS_PER_LINE) bits).
REQ-022 DATA: handshake with counter == BEATS_PER_LINE-1 SHALL return to IDLE and set rr_ptr to the non-granted requester.
REQ-023 Non-granted requester outputs, and all requester/memory outputs not listed for the current state, SHALL be 0; req_rdata_o of non-granted requester SHALL be 0.
REQ-024 Minimum arbitration latency: req_arvalid_i high in IDLE -> mem_arvalid_o high exactly 1 cycle later.
REQ-025 A requester asserting arvalid during another's ADDR/DATA SHALL wait; no preemption mid-line.
REQ-026 Back-to-back: request pending at return to IDLE SHALL be granted in that IDLE cycle (1 idle cycle between lines).
REQ-027 mem_rvalid_i while IDLE or ADDR SHALL be ignored (mem_rready_o=0).

Reset
REQ-028 On rst_ni low: state IDLE, grant 0, rr_ptr 0, beat counter 0; every output 0 (grant_o=0, busy_o=0) immediately and asynchronously.
REQ-029 Reset asserted mid-line SHALL abandon the transaction; no beats forwarded after deassertion until a new grant.

Structure
REQ-030 addr_t, word_t, ADDR_WIDTH SHALL come from riscv_core_pkg; mem_arb_state_e enum SHALL be added to riscv_core_pkg.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, rr_ptr; outputs grant index, any_req).
REQ-032 Target 120-250 lines RTL; no storage of data (pass-through only).

Verification
REQ-033 Only req0 arvalid, araddr 0x0000_1000, mem_arready 1, 8 beats 0xA0..0xA7 -> mem_araddr 0x0000_1000 one cycle after request, req0 receives 0xA0..0xA7, busy_o falls after beat 8, rr_ptr=1.
REQ-034 Both arvalid same cycle after reset (req0 0x1000, req1 0x2000) -> req0 served first, req1 granted in IDLE cycle right after req0 beat 8, mem_araddr 0x2000.
REQ-035 Repeated simultaneous requests for 4 lines -> grants alternate 0,1,0,1.
REQ-036 req1 rready low 3 cycles mid-line with mem_rvalid 1 -> mem_rready_o low those cycles, beat count holds, exactly 8 beats delivered.
REQ-037 rst_ni pulsed low after beat 4 of req0 line -> outputs 0 immediately, state IDLE, next req1 request granted normally.
REQ-038 req0 drops arvalid in ADDR with mem_arready 0 -> return to IDLE, no AR handshake, rr_ptr still 0.
